rtc_bus_sequencer: RTL and testbench
====================================

Name: rtc_bus_sequencer

Overview:
- Owns the multiplexed address/data bus of the external RTC chip (CS#, RD#, WR#, A/D select, AD[7:0]).
- Arbitrates between two sources: configuration writes coming from the port-register bank (date, time, timer values) and periodic read sweeps that refresh all nine time/date/timer registers.
- Sits between the PicoBlaze port-register bank and the chip pins; read-back values go to that bank's "le" inputs.

Parameters:
T_PHASE, 10, clock cycles per bus phase; legal range 2..255.
REFRESH_CYC, 1000000, clock cycles between automatic sweep requests; minimum 64.
SWEEP_LEN, 9, number of registers read per sweep; fixed by the package table.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_req  in  1  write request level; held high until wr_ack
wr_addr  in  8  RTC register address for the write
wr_data  in  8  data to write
wr_ack  out  1  one-cycle pulse when the write transaction completes
rd_valid  out  1  one-cycle pulse; rd_index/rd_data valid
rd_index  out  4  sweep slot 0..8 (year, month, day, hour, min, sec, timer h, m, s)
rd_data  out  8  byte sampled from the chip
sweep_done  out  1  one-cycle pulse after slot 8 completes
busy  out  1  high whenever the state is not IDLE
rtc_cs_n  out  1  chip select, active low
rtc_rd_n  out  1  read strobe, active low
rtc_wr_n  out  1  write strobe, active low
rtc_ad  out  1  0 = address phase, 1 = data phase
ad_out  out  8  value driven onto AD
ad_oe  out  1  AD output enable (the top level builds the tristate)
ad_in  in  8  AD pins as read back

Behaviour:
- Reset (asynchronous):
  - Outputs: all strobes 1; rtc_ad=0; ad_oe=0; ad_out=0; wr_ack=0; rd_valid=0; rd_index=0; rd_data=0; sweep_done=0; busy=0.
  - Internal: refresh counter=0, sweep_pending=0, slot=0.
  - Reset mid-transaction releases the strobes in the same instant; no partial transaction resumes.
- States: IDLE, ADDR, GAP, DATA, REC. A phase counter runs 0..T_PHASE-1 in each non-IDLE state, then the state advances.
- IDLE → ADDR, one cycle after a request is seen:
  - wr_req has priority over sweep_pending.
  - Latch the op type (write or read), address and data at the transition.
  - Read address = SWEEP_ADDR[slot].
- ADDR:
  - cs_n=0, wr_n=0, rtc_ad=0, ad_oe=1, ad_out=address.
- GAP:
  - All strobes 1, ad_oe=0.
- DATA:
  - cs_n=0 and rtc_ad=1 for the whole phase.
  - Write: wr_n=0, ad_oe=1, ad_out=data.
  - Read: rd_n=0, ad_oe=0; ad_in is sampled on the last cycle of DATA (phase count = T_PHASE-1).
- REC:
  - All strobes 1, ad_oe=0.
  - On the last REC cycle:
    - Write: wr_ack=1.
    - Read: rd_valid=1 with rd_index=slot and rd_data=sampled byte, then slot increments.
    - When slot was 8: sweep_done=1, slot←0, sweep_pending←0.
  - Next state is IDLE.
- Latency: a transaction occupies exactly 4*T_PHASE cycles plus one IDLE cycle.
- Arbitration is per transaction:
  - A pending write is inserted between sweep slots; the sweep resumes at the next slot afterwards.
  - wr_req seen in the same cycle as the refresh tick goes first.
- Refresh counter:
  - Free-running 0..REFRESH_CYC-1.
  - The wrap cycle sets sweep_pending.
  - A tick arriving while sweep_pending=1 is dropped, not queued.
- wr_req deasserted before the ack does not abort the transaction; the ack is still issued.
- wr_req still high one cycle after wr_ack starts a new write. Requesters must drop wr_req on the ack.
- rtc_rd_n and rtc_wr_n are never low simultaneously. ad_oe is never 1 while rd_n=0.

Decomposition:
- Package rtc_bus_pkg contains:
  - SWEEP_ADDR[0..8] = 26h, 25h, 24h, 23h, 22h, 21h, 43h, 42h, 41h;
  - SWEEP_LEN;
  - state encoding localparams;
  - op type constants.
- Sub-module rtc_refresh_timer (parameter REFRESH_CYC; output tick) holds the free-running counter.

Test Plan:
1. T_PHASE=4, REFRESH_CYC=1000; hold reset, then release → all outputs at reset values, rtc_cs_n=1; first rd_valid occurs only after the cycle-999 tick.
2. Idle bus, wr_req with addr=22h, data=59h → ADDR 4 cycles with ad_out=22h; GAP 4; DATA 4 with wr_n=0, ad_out=59h; REC 4; wr_ack exactly once, 17 cycles after the request.
3. Sweep with the chip model returning addr^FFh → nine rd_valid pulses with index 0..8 and data D9h, DAh, DBh, DCh, DDh, DEh, BCh, BDh, BEh; sweep_done after the 9th; 9*17 cycles total.
4. wr_req raised during slot 3 of a sweep → the write runs after slot 3's REC; slot 4 follows the ack; all nine slots are still delivered.
5. With REFRESH_CYC=64 and the sweep longer than 64 cycles, the tick arrives during the sweep → no second sweep is queued; exactly one sweep_done per sweep.
6. Reset asserted in the DATA phase of a write → rtc_wr_n and rtc_cs_n go to 1 asynchronously; no wr_ack; after release the block is in IDLE and the bus is quiet.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC bus sequencer: sweep register table, FSM
// state encoding and transaction op types.
package rtc_bus_pkg;

  localparam int SWEEP_LEN = 9;

  // year, month, day, hour, min, sec, timer h, timer m, timer s
  localparam logic [7:0] SWEEP_ADDR [0:SWEEP_LEN-1] = '{
    8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41
  };

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_REC  = 3'd4;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  function automatic logic [7:0] sweep_addr(input logic [3:0] slot);
    if (int'(slot) < SWEEP_LEN) return SWEEP_ADDR[slot];
    return 8'h00;
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh counter; tick is high for the single cycle at which
// the count wraps from REFRESH_CYC-1 back to zero.
module rtc_refresh_timer #(
  parameter int REFRESH_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(REFRESH_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Owns the RTC chip's multiplexed A/D bus: runs one write or one sweep read
// per transaction (ADDR, GAP, DATA, REC phases), writes taking priority.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE     = 10,
  parameter int REFRESH_CYC = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       rd_valid,
  output logic [3:0] rd_index,
  output logic [7:0] rd_data,
  output logic       sweep_done,
  output logic       busy,
  output logic       rtc_cs_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic       rtc_ad,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [7:0] PH_LAST   = 8'(T_PHASE - 1);
  localparam logic [3:0] SLOT_LAST = 4'(SWEEP_LEN - 1);

  logic [2:0] state, state_nxt;
  logic [7:0] phase, phase_nxt;
  logic       op, op_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] data_q, data_nxt;
  logic [7:0] rd_byte;
  logic [3:0] slot;
  logic       sweep_pending;
  logic       tick;
  logic       phase_end, last_rec, last_read, sweep_end;
  logic       cs_d, rd_d, wr_d, ad_d, oe_d;
  logic [7:0] out_d;

  rtc_refresh_timer #(.REFRESH_CYC(REFRESH_CYC)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign phase_end = (phase == PH_LAST);
  assign last_rec  = (state == ST_REC) && phase_end;
  assign last_read = last_rec && (op == OP_READ);
  assign sweep_end = last_read && (slot == SLOT_LAST);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    op_nxt    = op;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    case (state)
      ST_IDLE: begin
        phase_nxt = '0;
        if (wr_req) begin
          state_nxt = ST_ADDR;
          op_nxt    = OP_WRITE;
          addr_nxt  = wr_addr;
          data_nxt  = wr_data;
        end else if (sweep_pending) begin
          state_nxt = ST_ADDR;
          op_nxt    = OP_READ;
          addr_nxt  = sweep_addr(slot);
        end
      end
      ST_ADDR, ST_GAP, ST_DATA, ST_REC: begin
        if (phase_end) begin
          phase_nxt = '0;
          case (state)
            ST_ADDR: state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_DATA;
            ST_DATA: state_nxt = ST_REC;
            default: state_nxt = ST_IDLE;
          endcase
        end else begin
          phase_nxt = phase + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // Pin values are decoded from the next state so the strobes come straight
  // out of flops and cannot glitch at the chip.
  always_comb begin
    cs_d  = 1'b1;
    rd_d  = 1'b1;
    wr_d  = 1'b1;
    ad_d  = 1'b0;
    oe_d  = 1'b0;
    out_d = 8'h00;
    case (state_nxt)
      ST_ADDR: begin
        cs_d  = 1'b0;
        wr_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_nxt;
      end
      ST_DATA: begin
        cs_d = 1'b0;
        ad_d = 1'b1;
        if (op_nxt == OP_WRITE) begin
          wr_d  = 1'b0;
          oe_d  = 1'b1;
          out_d = data_nxt;
        end else begin
          rd_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase         <= '0;
      op            <= OP_WRITE;
      addr_q        <= '0;
      data_q        <= '0;
      rd_byte       <= '0;
      slot          <= '0;
      sweep_pending <= 1'b0;
      wr_ack        <= 1'b0;
      rd_valid      <= 1'b0;
      rd_index      <= '0;
      rd_data       <= '0;
      sweep_done    <= 1'b0;
      busy          <= 1'b0;
      rtc_cs_n      <= 1'b1;
      rtc_rd_n      <= 1'b1;
      rtc_wr_n      <= 1'b1;
      rtc_ad        <= 1'b0;
      ad_out        <= '0;
      ad_oe         <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      op       <= op_nxt;
      addr_q   <= addr_nxt;
      data_q   <= data_nxt;
      busy     <= (state_nxt != ST_IDLE);
      rtc_cs_n <= cs_d;
      rtc_rd_n <= rd_d;
      rtc_wr_n <= wr_d;
      rtc_ad   <= ad_d;
      ad_oe    <= oe_d;
      ad_out   <= out_d;

      // Read data is taken on the final DATA cycle, when the chip has had the
      // longest time to drive AD.
      if ((state == ST_DATA) && phase_end && (op == OP_READ)) begin
        rd_byte <= ad_in;
      end

      wr_ack     <= last_rec && (op == OP_WRITE);
      rd_valid   <= last_read;
      sweep_done <= sweep_end;
      if (last_read) begin
        rd_index <= slot;
        rd_data  <= rd_byte;
        slot     <= (slot == SLOT_LAST) ? 4'd0 : slot + 4'd1;
      end

      // A refresh tick while a sweep is still owed is simply dropped.
      if (sweep_end) begin
        sweep_pending <= 1'b0;
      end else if (tick) begin
        sweep_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: chip model answering reads with addr^FFh, write
// vector table, sweep/arbitration sequences, random writes and reset abort.
module tb_rtc_bus_sequencer;

  localparam int TP   = 4;
  localparam int RC   = 1000;
  localparam int RC64 = 64;
  localparam int TXN  = 4 * TP + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       rst64 = 1'b1;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, rd_valid, sweep_done, busy;
  logic [3:0] rd_index;
  logic [7:0] rd_data, ad_out, ad_in;
  logic       rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_oe;

  logic       wr_ack_b, rd_valid_b, sweep_done_b, busy_b;
  logic [3:0] rd_index_b;
  logic [7:0] rd_data_b, ad_out_b;
  logic       cs_n_b, rd_n_b, wr_n_b, rtc_ad_b, ad_oe_b;

  rtc_bus_sequencer #(.T_PHASE(TP), .REFRESH_CYC(RC)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .rd_valid(rd_valid), .rd_index(rd_index), .rd_data(rd_data),
    .sweep_done(sweep_done), .busy(busy), .rtc_cs_n(rtc_cs_n), .rtc_rd_n(rtc_rd_n),
    .rtc_wr_n(rtc_wr_n), .rtc_ad(rtc_ad), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  rtc_bus_sequencer #(.T_PHASE(TP), .REFRESH_CYC(RC64)) dut64 (
    .clk(clk), .reset(rst64), .wr_req(1'b0), .wr_addr(8'h00), .wr_data(8'h00),
    .wr_ack(wr_ack_b), .rd_valid(rd_valid_b), .rd_index(rd_index_b), .rd_data(rd_data_b),
    .sweep_done(sweep_done_b), .busy(busy_b), .rtc_cs_n(cs_n_b), .rtc_rd_n(rd_n_b),
    .rtc_wr_n(wr_n_b), .rtc_ad(rtc_ad_b), .ad_out(ad_out_b), .ad_oe(ad_oe_b), .ad_in(8'h00)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Chip model: latches the address phase, answers reads with addr^FFh and
  // records each completed write seen on the pins.
  logic [7:0] chip_addr = 8'h00;
  logic [7:0] bus_wa = 8'h00;
  logic [7:0] bus_wd = 8'h00;
  int         bus_wcnt = 0;
  bit         in_wd = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rtc_cs_n && !rtc_wr_n && !rtc_ad) chip_addr = ad_out;
    if (!rtc_cs_n && !rtc_wr_n && rtc_ad) begin
      in_wd  = 1'b1;
      bus_wa = chip_addr;
      bus_wd = ad_out;
    end else if (in_wd) begin
      in_wd = 1'b0;
      bus_wcnt++;
    end
  end

  assign ad_in = rtc_rd_n ? 8'h00 : (chip_addr ^ 8'hFF);

  // Sweep scoreboard: slots must come out 0..8 in order carrying the
  // documented register contents, sweep_done only alongside slot 8.
  logic [7:0] exp_rd [9] = '{8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE, 8'hBC, 8'hBD, 8'hBE};
  int exp_idx = 0;
  int n_rdv = 0, n_done = 0, n_ack = 0, last_done_cyc = 0;
  int rdv_cyc [9];

  initial begin
    for (int i = 0; i < 9; i++) rdv_cyc[i] = 0;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_idx = 0;
    end else begin
      if (rd_valid) begin
        n_rdv++;
        if (rd_index < 4'd9) rdv_cyc[rd_index] = cyc;
        check("rd_index order", int'(rd_index), exp_idx);
        check("rd_data", int'(rd_data), int'(exp_rd[exp_idx]));
        check("sweep_done with slot", int'(sweep_done), (exp_idx == 8) ? 1 : 0);
        exp_idx = (exp_idx + 1) % 9;
      end else if (sweep_done) begin
        check("sweep_done without rd_valid", int'(sweep_done), 0);
      end
      if (sweep_done) begin
        n_done++;
        last_done_cyc = cyc;
      end
      if (wr_ack) n_ack++;
      check("rd_n/wr_n overlap", int'(!rtc_rd_n && !rtc_wr_n), 0);
      check("ad_oe during read", int'(ad_oe && !rtc_rd_n), 0);
    end
  end

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int lo, input int hi,
                          input int ph, input string tag, output int ack_c);
    int  t0, w0, a0, na, nd;
    bit  got;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    t0 = cyc; w0 = bus_wcnt; na = 0; nd = 0; got = 1'b0; ack_c = -1;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (!rtc_cs_n && !rtc_wr_n && ad_oe) begin
        if (!rtc_ad && ad_out == a) na++;
        if (rtc_ad && ad_out == d) nd++;
      end
      if (wr_ack) begin
        got    = 1'b1;
        ack_c  = cyc;
        wr_req = 1'b0;
      end
    end
    wr_req = 1'b0;
    check({tag, " ack seen"}, int'(got), 1);
    if (got) begin
      check_range({tag, " latency"}, ack_c - t0, lo, hi);
      check({tag, " bus write count"}, bus_wcnt - w0, 1);
      check({tag, " bus addr"}, int'(bus_wa), int'(a));
      check({tag, " bus data"}, int'(bus_wd), int'(d));
      if (ph > 0) begin
        check({tag, " addr phase cycles"}, na, ph);
        check({tag, " data phase cycles"}, nd, ph);
      end
      a0 = n_ack;
      repeat (3) step();
      check({tag, " single ack"}, n_ack - a0, 0);
    end
  endtask

  // Short-refresh instance: a 153-cycle sweep spans two 64-cycle ticks, both
  // dropped, so sweeps land every third tick.
  bit done64 = 1'b0;
  initial begin : chk64
    int q, nd, nr;
    int dcyc [3];
    int rcnt [3];
    nd = 0; nr = 0;
    wait (!rst64);
    q = cyc;
    for (int i = 0; i < 1000 && nd < 3; i++) begin
      step();
      check("dut64 wr_ack idle", int'(wr_ack_b), 0);
      check("dut64 rd/wr overlap", int'(!rd_n_b && !wr_n_b), 0);
      check("dut64 oe during read", int'(ad_oe_b && !rd_n_b), 0);
      if (rd_valid_b) begin
        check("dut64 rd_index", int'(rd_index_b), nr % 9);
        check("dut64 rd_data", int'(rd_data_b), 0);
        check("dut64 busy at rd_valid", int'(busy_b), 0);
        nr++;
      end
      if (sweep_done_b) begin
        dcyc[nd] = cyc;
        rcnt[nd] = nr;
        nd++;
      end
    end
    check("dut64 sweeps seen", nd, 3);
    if (nd == 3) begin
      check("dut64 first sweep_done", dcyc[0] - q, RC64 + 9 * TXN);
      check("dut64 sweep spacing 1", dcyc[1] - dcyc[0], 3 * RC64);
      check("dut64 sweep spacing 2", dcyc[2] - dcyc[1], 3 * RC64);
      check("dut64 reads per sweep", rcnt[2] - rcnt[1], 9);
      check("dut64 total reads", rcnt[2], 27);
      check("dut64 ad_out idle", int'(ad_out_b), 0);
      check("dut64 rtc_ad idle", int'(rtc_ad_b), 0);
      check("dut64 cs idle", int'(cs_n_b), 1);
    end
    done64 = 1'b1;
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         lat;
    int         ph;
  } wvec_t;

  wvec_t wtab [4];

  initial begin : main
    int r, n0, t2, ack_c, a0, cs_low;
    bit found;
    wtab[0] = '{8'h22, 8'h59, TXN, TP};
    wtab[1] = '{8'h00, 8'hFF, TXN, TP};
    wtab[2] = '{8'hFF, 8'h00, TXN, TP};
    wtab[3] = '{8'hA5, 8'h5A, TXN, TP};

    repeat (3) step();
    check("rst cs_n", int'(rtc_cs_n), 1);
    check("rst rd_n", int'(rtc_rd_n), 1);
    check("rst wr_n", int'(rtc_wr_n), 1);
    check("rst rtc_ad", int'(rtc_ad), 0);
    check("rst ad_oe", int'(ad_oe), 0);
    check("rst ad_out", int'(ad_out), 0);
    check("rst wr_ack", int'(wr_ack), 0);
    check("rst rd_valid", int'(rd_valid), 0);
    check("rst rd_index", int'(rd_index), 0);
    check("rst rd_data", int'(rd_data), 0);
    check("rst sweep_done", int'(sweep_done), 0);
    check("rst busy", int'(busy), 0);

    reset = 1'b0;
    rst64 = 1'b0;
    r = cyc;
    step();
    check("idle cs_n after release", int'(rtc_cs_n), 1);

    foreach (wtab[i]) begin
      do_write(wtab[i].addr, wtab[i].data, wtab[i].lat, wtab[i].lat, wtab[i].ph, "table write", ack_c);
      repeat (2) step();
    end

    // First sweep waits for the wrap of the refresh counter.
    n0 = n_rdv;
    for (int i = 0; i < RC + 100 && n_rdv == n0; i++) step();
    check("first rd_valid cycle", rdv_cyc[0] - r, RC + TXN);
    a0 = n_done;
    for (int i = 0; i < 300 && n_done == a0; i++) step();
    check("sweep1 done cycle", last_done_cyc - r, RC + 9 * TXN);
    check("sweep1 reads", n_rdv - n0, 9);

    // Write raised while slot 3 is on the bus slots in right after it.
    t2 = -1;
    for (int i = 0; i < 1200 && t2 < 0; i++) begin
      step();
      if (rd_valid && rd_index == 4'd2) t2 = cyc;
    end
    check("sweep2 slot2 seen", int'(t2 >= 0), 1);
    repeat (5) step();
    n0 = n_rdv;
    do_write(8'h10, 8'hC3, 2 * TXN - 5, 2 * TXN - 5, -1, "mid-sweep write", ack_c);
    check("slot3 before write", rdv_cyc[3] - t2, TXN);
    check("write ack after slot3", ack_c - t2, 2 * TXN);
    a0 = n_done;
    for (int i = 0; i < 300 && n_done == a0; i++) step();
    check("slot4 after ack", rdv_cyc[4] - t2, 3 * TXN);
    check("sweep2 done cycle", last_done_cyc - t2, 7 * TXN);
    check("sweep2 remaining reads", n_rdv - n0, 6);

    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 30)) step();
      do_write(8'($urandom), 8'($urandom), TXN, 2 * TXN - 1, -1, "random write", ack_c);
    end

    // Reset in the DATA phase of a write drops the strobes without a clock.
    a0 = n_ack;
    wr_addr = 8'h30;
    wr_data = 8'h12;
    wr_req  = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (rtc_ad && !rtc_wr_n && ad_oe) found = 1'b1;
    end
    check("abort write reached DATA", int'(found), 1);
    reset = 1'b1;
    #1;
    check("abort wr_n async", int'(rtc_wr_n), 1);
    check("abort cs_n async", int'(rtc_cs_n), 1);
    check("abort ad_oe async", int'(ad_oe), 0);
    check("abort busy async", int'(busy), 0);
    wr_req = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    cs_low = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!rtc_cs_n) cs_low++;
    end
    check("abort no wr_ack", n_ack - a0, 0);
    check("abort bus quiet", cs_low, 0);
    check("abort busy after", int'(busy), 0);

    for (int i = 0; i < 2000 && !done64; i++) step();
    check("dut64 checker finished", int'(done64), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
